load_store_unit: RTL and testbench

Load/store unit between the MIPS execute stage and the 32-byte data memory. It accepts one memory request at a time and performs byte, halfword and word accesses on the memory's word-only port, using read-modify-write for sub-word stores. Loads return data with sign or zero extension applied. Misaligned and illegal requests fault without touching memory.

---
 rtl/load_store_unit_pkg.sv | 54 +++++
 rtl/load_store_unit_if.sv | 46 ++++
 rtl/load_store_unit_align.sv | 50 +++++
 rtl/load_store_unit.sv | 130 +++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM state encoding
// and small op-classification helpers used by the FSM and the lane logic.
package lsu_pkg;

    // Operation codes as presented on req_op.
    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // True only for the eight defined op codes.
    function automatic logic is_legal(input logic [3:0] op);
        logic ok;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: ok = 1'b1;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic is_byte(input logic [3:0] op);
        return (op[1:0] == 2'b00);
    endfunction

    function automatic logic is_half(input logic [3:0] op);
        return (op[1:0] == 2'b01);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op[1:0] == 2'b11);
    endfunction

    // LBU/LHU carry bit 2; no store uses it.
    function automatic logic is_unsigned(input logic [3:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the execute-side request/response channel and the data-memory
// port of the load/store unit.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high. req_ready is high only while the unit is idle, and
// the req_* fields are ignored at every other time. Each transferred request
// produces exactly one resp_valid pulse (one cycle) carrying resp_rdata and
// resp_fault, unless reset intervenes. There is no backpressure on responses.
interface load_store_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_fault;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    // Execute stage plus data memory (the environment around the unit).
    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_fault,
        input  mem_address, mem_read, mem_write, mem_write_data,
        output mem_read_data
    );

    // The load/store unit itself.
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_fault,
        output mem_address, mem_read, mem_write, mem_write_data,
        input  mem_read_data
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Purely combinational lane logic: load extraction with sign/zero extension,
// sub-word merge into a read word for stores, and the alignment/legality check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o,
    output logic        fault_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Pick the addressed lane out of the little-endian word and extend it.
    always_comb begin
        ld_byte = rd_word_i[{lane_i, 3'b000} +: 8];
        ld_half = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
        if (is_byte(op_i)) begin
            ld_data_o = is_unsigned(op_i) ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (is_half(op_i)) begin
            ld_data_o = is_unsigned(op_i) ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
        end else begin
            ld_data_o = rd_word_i;
        end
    end

    // Replace only the target lane; every other byte keeps its read value.
    always_comb begin
        st_word_o = rd_word_i;
        if (is_byte(op_i)) begin
            st_word_o[{lane_i, 3'b000} +: 8] = st_data_i[7:0];
        end else if (is_half(op_i)) begin
            st_word_o[{lane_i[1], 4'b0000} +: 16] = st_data_i[15:0];
        end else begin
            st_word_o = st_data_i;
        end
    end

    // Illegal codes and accesses not aligned to their own size fault.
    always_comb begin
        fault_o = !is_legal(op_i)
                || (is_half(op_i) && lane_i[0])
                || (is_word(op_i) && (lane_i != 2'b00));
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-only data memory.
// One request in flight at a time; sub-word stores use read-modify-write.
// Memory-side outputs decode from registered state only, so they are stable
// across the memory's negedge read and its posedge write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32   // only 32 is supported
) (
    input  logic                clock,
    input  logic                reset,
    load_store_unit_if.slave    bus,
    output lsu_state_e          dbg_state_o
);

    lsu_state_e        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] word_q, word_d;    // store data, then merged write word
    logic [DATA_W-1:0] rdata_q, rdata_d;  // extended load result
    logic              fault_q, fault_d;

    logic [3:0]        al_op;
    logic [1:0]        al_lane;
    logic [31:0]       al_ld_data;
    logic [31:0]       al_st_word;
    logic              al_fault;

    // While idle the checker looks at the incoming request; afterwards the
    // lane logic works on the latched copy only.
    always_comb begin
        if (state_q == ST_IDLE) begin
            al_op   = bus.req_op;
            al_lane = bus.req_addr[1:0];
        end else begin
            al_op   = op_q;
            al_lane = addr_q[1:0];
        end
    end

    lsu_align u_align (
        .op_i      (al_op),
        .lane_i    (al_lane),
        .rd_word_i (bus.mem_read_data),
        .st_data_i (word_q),
        .ld_data_o (al_ld_data),
        .st_word_o (al_st_word),
        .fault_o   (al_fault)
    );

    // State and latched-request registers; reset aborts any access at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Next-state and register updates for the IDLE/READ/WRITE/RESP sequence.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    word_d  = bus.req_wdata;
                    rdata_d = '0;
                    fault_d = al_fault;
                    if (al_fault) begin
                        state_d = ST_RESP;
                    end else if (is_store(bus.req_op) && is_word(bus.req_op)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (is_store(op_q)) begin
                    word_d  = al_st_word;
                    state_d = ST_WRITE;
                end else begin
                    rdata_d = al_ld_data;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        bus.req_ready      = (state_q == ST_IDLE);
        bus.resp_valid     = (state_q == ST_RESP);
        bus.resp_rdata     = (state_q == ST_RESP) ? rdata_q : '0;
        bus.resp_fault     = (state_q == ST_RESP) && fault_q;
        bus.mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
        bus.mem_read       = (state_q == ST_READ);
        bus.mem_write      = (state_q == ST_WRITE);
        bus.mem_write_data = (state_q == ST_WRITE) ? word_q : '0;
        dbg_state_o        = state_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-array memory model
// (negedge read, posedge write) and hand-computed expected results.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic       clock;
    logic       reset;
    lsu_state_e dbg_state;

    int n_cmp;
    int n_mis;

    load_store_unit_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    load_store_unit #(.ADDR_W(5), .DATA_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory model ----------------
    logic [31:0] mem [8] = '{32'h0000_0000, 32'h0000_0000, 32'h1111_1111, 32'hCAFE_F00D,
                             32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    always @(negedge clock) begin
        if (bus.mem_read) bus.mem_read_data <= mem[bus.mem_address[4:2]];
    end

    always @(posedge clock) begin
        if (bus.mem_write) mem[bus.mem_address[4:2]] <= bus.mem_write_data;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issue one request, then follow it to its response, counting latency
    // (negedges after the accepting edge) and memory enable cycles.
    task automatic do_req(input string tag, input logic [3:0] op, input logic [4:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_fault, input int exp_lat,
                          input int exp_rd, input int exp_wr);
        int  guard;
        int  cyc;
        int  rd;
        int  wr;
        bit  got;
        guard = 0;
        @(negedge clock);
        while (!bus.req_ready && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        check_eq({tag, ".ready"}, {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clock);
        // Scramble the request fields: the unit must work from its latched copy.
        bus.req_valid = 1'b0;
        bus.req_op    = 4'($urandom_range(0, 15));
        bus.req_addr  = 5'($urandom_range(0, 31));
        bus.req_wdata = $urandom;
        cyc = 1;
        rd  = 0;
        wr  = 0;
        got = 1'b0;
        while (!got && cyc <= 10) begin
            if (bus.mem_read)  rd++;
            if (bus.mem_write) wr++;
            if (bus.resp_valid) begin
                got = 1'b1;
                check_eq({tag, ".rdata"}, bus.resp_rdata, exp_rdata);
                check_eq({tag, ".fault"}, {31'b0, bus.resp_fault}, {31'b0, exp_fault});
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        check_eq({tag, ".resp_seen"}, {31'b0, got}, 32'd1);
        check_eq({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
        check_eq({tag, ".read_cycles"}, 32'(rd), 32'(exp_rd));
        check_eq({tag, ".write_cycles"}, 32'(wr), 32'(exp_wr));
    endtask

    // ---------------- stimulus ----------------
    logic [3:0]  b_op   [3];
    logic [4:0]  b_addr [3];
    logic [31:0] b_wd   [3];
    logic [31:0] exp_q  [$];
    int          acc    [3];

    initial begin
        int  idx;
        int  cyc;
        int  nresp;
        bit  pending;
        bit  seen;
        logic [31:0] exp_v;

        n_cmp = 0;
        n_mis = 0;
        reset = 1'b1;
        bus.req_valid     = 1'b0;
        bus.req_op        = 4'b0;
        bus.req_addr      = 5'b0;
        bus.req_wdata     = 32'b0;
        bus.mem_read_data = 32'b0;

        // Reset values, held across a clock edge.
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst.req_ready", {31'b0, bus.req_ready}, 32'd1);
        check_eq("rst.resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check_eq("rst.resp_rdata", bus.resp_rdata, 32'd0);
        check_eq("rst.resp_fault", {31'b0, bus.resp_fault}, 32'd0);
        check_eq("rst.mem_read", {31'b0, bus.mem_read}, 32'd0);
        check_eq("rst.mem_write", {31'b0, bus.mem_write}, 32'd0);
        check_eq("rst.mem_address", {27'b0, bus.mem_address}, 32'd0);
        check_eq("rst.mem_write_data", bus.mem_write_data, 32'd0);
        check_eq("rst.state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clock);
        reset = 1'b0;

        // Basic word load and byte store read-modify-write.
        do_req("lw16",   OP_LW,  5'd16, 32'h0,         32'h0000_0002, 1'b0, 2, 1, 0);
        do_req("sb17",   OP_SB,  5'd17, 32'h0000_00AB, 32'h0,         1'b0, 3, 1, 1);
        do_req("lw16b",  OP_LW,  5'd16, 32'h0,         32'h0000_AB02, 1'b0, 2, 1, 0);

        // Sign/zero extension; word 16 becomes 0x0080AB02 then 0x8080AB02.
        do_req("sb18",   OP_SB,  5'd18, 32'h0000_0080, 32'h0,         1'b0, 3, 1, 1);
        do_req("lb18",   OP_LB,  5'd18, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 1, 0);
        do_req("lbu18",  OP_LBU, 5'd18, 32'h0,         32'h0000_0080, 1'b0, 2, 1, 0);
        do_req("lh18",   OP_LH,  5'd18, 32'h0,         32'h0000_0080, 1'b0, 2, 1, 0);
        do_req("lb17",   OP_LB,  5'd17, 32'h0,         32'hFFFF_FFAB, 1'b0, 2, 1, 0);
        do_req("lb16",   OP_LB,  5'd16, 32'h0,         32'h0000_0002, 1'b0, 2, 1, 0);
        do_req("sb19",   OP_SB,  5'd19, 32'hFFFF_FF80, 32'h0,         1'b0, 3, 1, 1);
        do_req("lh18b",  OP_LH,  5'd18, 32'h0,         32'hFFFF_8080, 1'b0, 2, 1, 0);
        do_req("lhu16",  OP_LHU, 5'd16, 32'h0,         32'h0000_AB02, 1'b0, 2, 1, 0);
        do_req("lh16",   OP_LH,  5'd16, 32'h0,         32'hFFFF_AB02, 1'b0, 2, 1, 0);

        // Halfword stores into both lanes of word 20; upper store bits ignored.
        do_req("sh20",   OP_SH,  5'd20, 32'hFFFF_1234, 32'h0,         1'b0, 3, 1, 1);
        do_req("sh22",   OP_SH,  5'd22, 32'hAAAA_5678, 32'h0,         1'b0, 3, 1, 1);
        do_req("lw20",   OP_LW,  5'd20, 32'h0,         32'h5678_1234, 1'b0, 2, 1, 0);

        // Faults: no memory access, one-cycle latency, zero data.
        do_req("f_lh17", OP_LH,  5'd17, 32'h0,         32'h0,         1'b1, 1, 0, 0);
        do_req("f_sw6",  OP_SW,  5'd6,  32'h5555_5555, 32'h0,         1'b1, 1, 0, 0);
        do_req("f_op7",  4'b0111, 5'd0, 32'h0,         32'h0,         1'b1, 1, 0, 0);
        do_req("f_op15", 4'b1111, 5'd4, 32'h0,         32'h0,         1'b1, 1, 0, 0);
        check_eq("f_sw6.mem_unchanged", mem[1], 32'h0000_0000);

        // Back-to-back with req_valid held high throughout.
        b_op[0] = OP_SW;  b_addr[0] = 5'd8;  b_wd[0] = 32'hDEAD_BEEF;
        b_op[1] = OP_LHU; b_addr[1] = 5'd10; b_wd[1] = 32'h0123_4567;
        b_op[2] = OP_LHU; b_addr[2] = 5'd8;  b_wd[2] = 32'h89AB_CDEF;
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_DEAD);
        exp_q.push_back(32'h0000_BEEF);
        @(negedge clock);
        idx = 0;
        cyc = 0;
        nresp = 0;
        pending = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = b_op[0];
        bus.req_addr  = b_addr[0];
        bus.req_wdata = b_wd[0];
        while ((idx < 3 || nresp < 3) && cyc < 60) begin
            if (pending) begin
                idx++;
                pending = 1'b0;
                if (idx < 3) begin
                    bus.req_op    = b_op[idx];
                    bus.req_addr  = b_addr[idx];
                    bus.req_wdata = b_wd[idx];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            if (bus.resp_valid) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
                check_eq("b2b.rdata", bus.resp_rdata, exp_v);
                check_eq("b2b.fault", {31'b0, bus.resp_fault}, 32'd0);
                nresp++;
            end
            if (idx < 3 && bus.req_ready) begin
                check_eq("b2b.accept_state", 32'(dbg_state), 32'(ST_IDLE));
                acc[idx] = cyc;
                pending = 1'b1;
            end
            @(negedge clock);
            cyc++;
        end
        bus.req_valid = 1'b0;
        check_eq("b2b.responses", 32'(nresp), 32'd3);
        check_eq("b2b.gap01", 32'(acc[1] - acc[0]), 32'd3);
        check_eq("b2b.gap12", 32'(acc[2] - acc[1]), 32'd3);
        check_eq("b2b.mem8", mem[2], 32'hDEAD_BEEF);

        // Reset during the WRITE state of SW 12.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SW;
        bus.req_addr  = 5'd12;
        bus.req_wdata = 32'h1234_5678;
        @(negedge clock);
        bus.req_valid = 1'b0;
        check_eq("abort.in_write", 32'(dbg_state), 32'(ST_WRITE));
        check_eq("abort.mem_write_before", {31'b0, bus.mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("abort.mem_write_drop", {31'b0, bus.mem_write}, 32'd0);
        check_eq("abort.ready_in_reset", {31'b0, bus.req_ready}, 32'd1);
        seen = 1'b0;
        @(negedge clock);
        if (bus.resp_valid) seen = 1'b1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (bus.resp_valid) seen = 1'b1;
        end
        check_eq("abort.no_resp", {31'b0, seen}, 32'd0);
        check_eq("abort.ready_after", {31'b0, bus.req_ready}, 32'd1);
        check_eq("abort.mem12", mem[3], 32'hCAFE_F00D);
        do_req("lw12",   OP_LW,  5'd12, 32'h0,         32'hCAFE_F00D, 1'b0, 2, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
